median_frame_sequencer: RTL and testbench

Frame-level controller for the median-filter wake-up path. Owns the single port of the flat image memory, arbitrating it between the incoming pixel stream (load phase) and the median engine (run phase). Sequences each frame through load, engine clear, run, and threshold evaluation, then publishes the wake-up decision. Sits between the sensor pixel interface and the existing memory/median-engine pair.

---
 rtl/median_pkg.sv | 31 +++
 rtl/median_raster_counter.sv | 53 +++++
 rtl/median_frame_sequencer.sv | 175 +++++++++++++++++
 tb/tb_median_frame_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and sizes for the median-filter wake-up path.
package median_pkg;

   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned CNT_W     = 13;
   localparam int unsigned TMO_W     = 20;
   localparam int unsigned DEF_XSIZE = 160;
   localparam int unsigned DEF_YSIZE = 120;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_CLEAR = 3'd3,
      ST_RUN   = 3'd4,
      ST_EVAL  = 3'd5
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] x;
      logic [ADDR_W-1:0] y;
      logic              data;
   } mem_wr_t;

   // Wake-up fires only when strictly more windows are active than the threshold.
   function automatic logic wake_decision(input logic [CNT_W-1:0] windows,
                                          input logic [CNT_W-1:0] thr);
      return windows > thr;
   endfunction

endpackage

// File: rtl/median_raster_counter.sv
// Raster-order x/y position counter with wrap and last-pixel flag.
module median_raster_counter
   import median_pkg::*;
#(
   parameter int unsigned XSIZE = DEF_XSIZE,
   parameter int unsigned YSIZE = DEF_YSIZE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              adv,
   output logic [ADDR_W-1:0] x,
   output logic [ADDR_W-1:0] y,
   output logic              last_c
);

   localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(XSIZE - 1);
   localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(YSIZE - 1);

   logic [ADDR_W-1:0] x_q, x_d;
   logic [ADDR_W-1:0] y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr) begin
         x_d = '0;
         y_d = '0;
      end else if (adv) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + ADDR_W'(1);
         end else begin
            x_d = x_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign last_c = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/median_frame_sequencer.sv
// Frame controller: owns the image memory port across load/run and
// sequences load, engine clear, run and threshold evaluation.
module median_frame_sequencer
   import median_pkg::*;
#(
   parameter int unsigned      XSIZE   = DEF_XSIZE,
   parameter int unsigned      YSIZE   = DEF_YSIZE,
   parameter logic [TMO_W-1:0] TIMEOUT = 20'd1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frameReq,
   input  logic              abort,
   input  logic [CNT_W-1:0]  threshold,
   input  logic              pixValid,
   output logic              pixReady,
   input  logic              pixData,
   output logic              memWrite,
   output logic [ADDR_W-1:0] memXAddr,
   output logic [ADDR_W-1:0] memYAddr,
   output logic              memData,
   output logic              engineClear,
   output logic              engineStart,
   input  logic              fullImageDone,
   input  logic [CNT_W-1:0]  activeWindows,
   output logic              wakeUp,
   output logic              frameDone,
   output logic              busy,
   output logic              timeoutErr
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  thr_q, thr_d;
   logic [TMO_W-1:0]  tcnt_q, tcnt_d;
   mem_wr_t           wr_q, wr_d;
   logic              mem_write_q, mem_write_d;
   logic              pix_ready_q, pix_ready_d;
   logic              engine_clear_q, engine_clear_d;
   logic              engine_start_q, engine_start_d;
   logic              wake_up_q, wake_up_d;
   logic              frame_done_q, frame_done_d;
   logic              busy_q, busy_d;
   logic              timeout_err_q, timeout_err_d;

   logic              xfer_c;
   logic              cnt_clr_c;
   logic              cnt_adv_c;
   logic [ADDR_W-1:0] pix_x;
   logic [ADDR_W-1:0] pix_y;
   logic              last_pix_c;

   assign xfer_c    = (state_q == ST_LOAD) && pix_ready_q && pixValid;
   assign cnt_clr_c = (state_q == ST_IDLE);
   assign cnt_adv_c = xfer_c && !abort;

   median_raster_counter #(
      .XSIZE (XSIZE),
      .YSIZE (YSIZE)
   ) u_raster (
      .clk    (clk),
      .rst_n  (reset),
      .clr    (cnt_clr_c),
      .adv    (cnt_adv_c),
      .x      (pix_x),
      .y      (pix_y),
      .last_c (last_pix_c)
   );

   // Next state and next registered outputs.
   always_comb begin
      state_d       = state_q;
      thr_d         = thr_q;
      tcnt_d        = tcnt_q;
      wr_d          = wr_q;
      mem_write_d   = 1'b0;
      frame_done_d  = 1'b0;
      wake_up_d     = wake_up_q;
      timeout_err_d = timeout_err_q;

      case (state_q)
         ST_IDLE: begin
            if (frameReq) begin
               state_d       = ST_LOAD;
               thr_d         = threshold;
               timeout_err_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (xfer_c) begin
               mem_write_d = 1'b1;
               wr_d.x      = pix_x;
               wr_d.y      = pix_y;
               wr_d.data   = pixData;
               if (last_pix_c) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: state_d = ST_CLEAR;
         ST_CLEAR: begin
            state_d = ST_RUN;
            tcnt_d  = '0;
         end
         ST_RUN: begin
            tcnt_d = tcnt_q + TMO_W'(1);
            if (fullImageDone) begin
               state_d      = ST_EVAL;
               wake_up_d    = wake_decision(activeWindows, thr_q);
               frame_done_d = 1'b1;
            end else if (tcnt_q == TIMEOUT - TMO_W'(1)) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
               frame_done_d  = 1'b1;
            end
         end
         ST_EVAL:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Abort overrides everything; EVAL has already reported its frame end.
      if (abort && (state_q != ST_IDLE) && (state_q != ST_EVAL)) begin
         state_d       = ST_IDLE;
         mem_write_d   = 1'b0;
         frame_done_d  = 1'b1;
         wake_up_d     = wake_up_q;
         timeout_err_d = timeout_err_q;
      end

      pix_ready_d    = (state_d == ST_LOAD);
      engine_clear_d = (state_d == ST_CLEAR);
      engine_start_d = (state_d == ST_RUN);
      busy_d         = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         thr_q          <= '0;
         tcnt_q         <= '0;
         wr_q           <= '0;
         mem_write_q    <= 1'b0;
         pix_ready_q    <= 1'b0;
         engine_clear_q <= 1'b0;
         engine_start_q <= 1'b0;
         wake_up_q      <= 1'b0;
         frame_done_q   <= 1'b0;
         busy_q         <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         thr_q          <= thr_d;
         tcnt_q         <= tcnt_d;
         wr_q           <= wr_d;
         mem_write_q    <= mem_write_d;
         pix_ready_q    <= pix_ready_d;
         engine_clear_q <= engine_clear_d;
         engine_start_q <= engine_start_d;
         wake_up_q      <= wake_up_d;
         frame_done_q   <= frame_done_d;
         busy_q         <= busy_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign pixReady    = pix_ready_q;
   assign memWrite    = mem_write_q;
   assign memXAddr    = wr_q.x;
   assign memYAddr    = wr_q.y;
   assign memData     = wr_q.data;
   assign engineClear = engine_clear_q;
   assign engineStart = engine_start_q;
   assign wakeUp      = wake_up_q;
   assign frameDone   = frame_done_q;
   assign busy        = busy_q;
   assign timeoutErr  = timeout_err_q;

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Directed bench for median_frame_sequencer on a 4x3 frame with a short run timeout.
module tb_median_frame_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frameReq = 1'b0;
   logic        abort = 1'b0;
   logic [12:0] threshold = '0;
   logic        pixValid = 1'b0;
   logic        pixReady;
   logic        pixData = 1'b0;
   logic        memWrite;
   logic [7:0]  memXAddr;
   logic [7:0]  memYAddr;
   logic        memData;
   logic        engineClear;
   logic        engineStart;
   logic        fullImageDone = 1'b0;
   logic [12:0] activeWindows = '0;
   logic        wakeUp;
   logic        frameDone;
   logic        busy;
   logic        timeoutErr;

   int tests = 0;
   int errors = 0;
   int done_cnt = 0;
   int clr_cnt = 0;
   int exp_done = 0;
   int exp_clr = 0;
   logic [16:0] wr_log[$];
   logic [11:0] pat = 12'b1011_0010_1101;

   median_frame_sequencer #(
      .XSIZE   (4),
      .YSIZE   (3),
      .TIMEOUT (20'd50)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .frameReq      (frameReq),
      .abort         (abort),
      .threshold     (threshold),
      .pixValid      (pixValid),
      .pixReady      (pixReady),
      .pixData       (pixData),
      .memWrite      (memWrite),
      .memXAddr      (memXAddr),
      .memYAddr      (memYAddr),
      .memData       (memData),
      .engineClear   (engineClear),
      .engineStart   (engineStart),
      .fullImageDone (fullImageDone),
      .activeWindows (activeWindows),
      .wakeUp        (wakeUp),
      .frameDone     (frameDone),
      .busy          (busy),
      .timeoutErr    (timeoutErr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (memWrite) wr_log.push_back({memXAddr, memYAddr, memData});
      if (frameDone) done_cnt++;
      if (engineClear) clr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag, input logic exp_wake, input logic exp_terr);
      check({tag, "_rdy"},   32'(pixReady), 0);
      check({tag, "_mw"},    32'(memWrite), 0);
      check({tag, "_clr"},   32'(engineClear), 0);
      check({tag, "_start"}, 32'(engineStart), 0);
      check({tag, "_wake"},  32'(wakeUp), 32'(exp_wake));
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_terr"},  32'(timeoutErr), 32'(exp_terr));
   endtask

   task automatic check_writes(input int n);
      check("wr_count", 32'(wr_log.size()), 32'(n));
      for (int i = 0; i < n && i < wr_log.size(); i++)
         check("wr_entry", 32'(wr_log[i]), 32'({8'(i % 4), 8'(i / 4), pat[i]}));
      wr_log.delete();
   endtask

   task automatic check_done_count();
      exp_done++;
      check("frame_done_count", 32'(done_cnt), 32'(exp_done));
   endtask

   task automatic start_frame(input logic [12:0] thr);
      frameReq  = 1'b1;
      threshold = thr;
      tick();
      frameReq = 1'b0;
      check("accept_busy", 32'(busy), 1);
      check("accept_rdy", 32'(pixReady), 1);
   endtask

   task automatic load_pixels(input int n, input bit gaps);
      int  idx = 0;
      int  cyc = 0;
      logic rdy;
      while (idx < n && cyc < 2000) begin
         pixValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         pixData  = pat[idx];
         rdy      = pixReady;
         tick();
         cyc++;
         if (pixValid && rdy) idx++;
      end
      pixValid = 1'b0;
      check("load_done", 32'(idx), 32'(n));
   endtask

   // Full 12-pixel load; leaves the bench in the first RUN cycle.
   task automatic load_and_run(input logic [12:0] thr, input bit gaps);
      start_frame(thr);
      load_pixels(12, gaps);
      check("flush_rdy", 32'(pixReady), 0);
      check("flush_mw", 32'(memWrite), 1);
      check("flush_busy", 32'(busy), 1);
      tick();
      check("clear_pulse", 32'(engineClear), 1);
      check("clear_mw", 32'(memWrite), 0);
      tick();
      check("run_start", 32'(engineStart), 1);
      check("run_clr_off", 32'(engineClear), 0);
      exp_clr++;
      check("clear_count", 32'(clr_cnt), 32'(exp_clr));
      check_writes(12);
   endtask

   task automatic finish_frame(input logic [12:0] aw, input logic exp_wake);
      fullImageDone = 1'b1;
      activeWindows = aw;
      tick();
      fullImageDone = 1'b0;
      check("eval_wake", 32'(wakeUp), 32'(exp_wake));
      check("eval_done", 32'(frameDone), 1);
      check("eval_busy", 32'(busy), 1);
      tick();
      check("post_eval_busy", 32'(busy), 0);
      check("post_eval_done", 32'(frameDone), 0);
      check_done_count();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_done", 32'(frameDone), 0);
      check_idle_outputs("rst", 1'b0, 1'b0);
      check("rst_xaddr", 32'(memXAddr), 0);
      reset = 1'b1;
      tick();
      check_idle_outputs("idle", 1'b0, 1'b0);

      // Continuous load, 101 > 100
      load_and_run(13'd100, 1'b0);
      finish_frame(13'd101, 1'b1);

      // Gapped load, 100 is not > 100
      load_and_run(13'd100, 1'b1);
      finish_frame(13'd100, 1'b0);

      // Run timeout at RUN cycle 50
      load_and_run(13'd100, 1'b0);
      repeat (49) tick();
      check("tmo_early_done", 32'(frameDone), 0);
      check("tmo_early_busy", 32'(busy), 1);
      tick();
      check("tmo_done", 32'(frameDone), 1);
      check("tmo_err", 32'(timeoutErr), 1);
      check("tmo_busy", 32'(busy), 0);
      check("tmo_wake", 32'(wakeUp), 0);
      tick();
      check("tmo_done_pulse", 32'(frameDone), 0);
      check("tmo_err_sticky", 32'(timeoutErr), 1);
      check_done_count();

      // New frame clears timeoutErr; abort mid-load at pixel 5
      start_frame(13'd100);
      check("tmo_err_cleared", 32'(timeoutErr), 0);
      load_pixels(5, 1'b0);
      abort    = 1'b1;
      pixValid = 1'b1;
      pixData  = pat[5];
      tick();
      abort    = 1'b0;
      pixValid = 1'b0;
      check("abort_load_done", 32'(frameDone), 1);
      check_idle_outputs("abort_load", 1'b0, 1'b0);
      repeat (3) tick();
      check("abort_load_quiet", 32'(memWrite), 0);
      check_writes(5);
      check_done_count();

      // Abort coincident with fullImageDone
      load_and_run(13'd100, 1'b0);
      fullImageDone = 1'b1;
      activeWindows = 13'd4000;
      abort         = 1'b1;
      tick();
      fullImageDone = 1'b0;
      abort         = 1'b0;
      check("abort_run_done", 32'(frameDone), 1);
      check_idle_outputs("abort_run", 1'b0, 1'b0);
      tick();
      check("abort_run_pulse", 32'(frameDone), 0);
      check_done_count();

      // Gapped load, 151 > 150
      load_and_run(13'd150, 1'b1);
      finish_frame(13'd151, 1'b1);

      // Asynchronous reset mid-RUN, then a normal frame
      load_and_run(13'd150, 1'b0);
      repeat (3) tick();
      #2 reset = 1'b0;
      #1;
      check("arst_done", 32'(frameDone), 0);
      check_idle_outputs("arst", 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      check_idle_outputs("post_arst", 1'b0, 1'b0);
      load_and_run(13'd0, 1'b0);
      finish_frame(13'd1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
